lfsr_checker: RTL and testbench



---
 rtl/lfsr_checker_if.sv | 24 ++
 rtl/lfsr_checker.sv | 139 +++++++++++++
 tb/tb_lfsr_checker.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/lfsr_checker_if.sv
// Stream and status bundle between a pattern source and the LFSR checker.
// The source drives the word stream; the checker returns lock state and error counts.
interface lfsr_checker_if #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             clr_counts;
    logic             locked;
    logic             err_pulse;
    logic [CNT_W-1:0] match_count;
    logic [CNT_W-1:0] err_count;

    modport master (
        output in_valid, in_data, clr_counts,
        input  locked, err_pulse, match_count, err_count
    );

    modport slave (
        input  in_valid, in_data, clr_counts,
        output locked, err_pulse, match_count, err_count
    );
endinterface

// File: rtl/lfsr_checker.sv
// Self-synchronising checker for a Fibonacci LFSR word stream: hunts, seeds its
// predictor, declares lock, then counts matching and mismatching words.
module lfsr_checker #(
    parameter int               WIDTH      = 16,
    parameter logic [WIDTH-1:0] TAPS       = 16'hB400,
    parameter int               LOCK_COUNT = 4,
    parameter int               LOSS_COUNT = 3,
    parameter int               CNT_W      = 16
) (
    input  logic          clk,
    input  logic          reset,
    lfsr_checker_if.slave bus
);
    localparam int RUN_W  = $clog2(LOCK_COUNT + 1);
    localparam int MISS_W = $clog2(LOSS_COUNT + 1);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] d);
        return {d[WIDTH-2:0], ^(d & TAPS)};
    endfunction

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  exp_q, exp_d;
    logic [RUN_W-1:0]  run_q, run_d;
    logic [MISS_W-1:0] miss_q, miss_d;
    logic              locked_q, locked_d;
    logic              err_pulse_q, err_pulse_d;
    logic [CNT_W-1:0]  match_q, match_d;
    logic [CNT_W-1:0]  err_q, err_d;
    logic              match_inc, err_inc;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= HUNT;
            exp_q       <= '0;
            run_q       <= '0;
            miss_q      <= '0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            match_q     <= '0;
            err_q       <= '0;
        end else begin
            state_q     <= state_d;
            exp_q       <= exp_d;
            run_q       <= run_d;
            miss_q      <= miss_d;
            locked_q    <= locked_d;
            err_pulse_q <= err_pulse_d;
            match_q     <= match_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        exp_d       = exp_q;
        run_d       = run_q;
        miss_d      = miss_q;
        locked_d    = locked_q;
        err_pulse_d = 1'b0;
        match_inc   = 1'b0;
        err_inc     = 1'b0;

        if (bus.in_valid) begin
            case (state_q)
                HUNT: begin
                    // The all-zero word is the LFSR lock-up state and can never seed.
                    if (bus.in_data != '0) begin
                        exp_d   = lfsr_next(bus.in_data);
                        run_d   = RUN_W'(1);
                        state_d = SYNC;
                    end
                end
                SYNC: begin
                    if (bus.in_data == '0) begin
                        run_d   = '0;
                        state_d = HUNT;
                    end else if (bus.in_data == exp_q) begin
                        exp_d = lfsr_next(bus.in_data);
                        run_d = run_q + RUN_W'(1);
                        if (run_q + RUN_W'(1) == RUN_W'(LOCK_COUNT)) begin
                            state_d  = LOCKED;
                            locked_d = 1'b1;
                            miss_d   = '0;
                        end
                    end else begin
                        exp_d = lfsr_next(bus.in_data);
                        run_d = RUN_W'(1);
                    end
                end
                LOCKED: begin
                    // Flywheel on the predictor so corrupted words never re-seed it.
                    exp_d = lfsr_next(exp_q);
                    if (bus.in_data == exp_q) begin
                        miss_d    = '0;
                        match_inc = 1'b1;
                    end else begin
                        err_inc     = 1'b1;
                        err_pulse_d = 1'b1;
                        miss_d      = miss_q + MISS_W'(1);
                        if (miss_q + MISS_W'(1) == MISS_W'(LOSS_COUNT)) begin
                            state_d  = HUNT;
                            locked_d = 1'b0;
                            miss_d   = '0;
                            run_d    = '0;
                        end
                    end
                end
                default: begin
                    state_d = HUNT;
                end
            endcase
        end

        match_d = match_q;
        if (bus.clr_counts) begin
            match_d = '0;
        end else if (match_inc && (match_q != '1)) begin
            match_d = match_q + CNT_W'(1);
        end

        err_d = err_q;
        if (bus.clr_counts) begin
            err_d = '0;
        end else if (err_inc && (err_q != '1)) begin
            err_d = err_q + CNT_W'(1);
        end
    end

    assign bus.locked      = locked_q;
    assign bus.err_pulse   = err_pulse_q;
    assign bus.match_count = match_q;
    assign bus.err_count   = err_q;
endmodule

// File: tb/tb_lfsr_checker.sv
// Directed bench for lfsr_checker: lock, tracking, loss, hunt, clear/reset,
// and counter saturation on a narrow-counter instance.
module tb_lfsr_checker;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    lfsr_checker_if #(.WIDTH(16), .CNT_W(16)) bus_a ();
    lfsr_checker_if #(.WIDTH(16), .CNT_W(4))  bus_b ();

    lfsr_checker #(.CNT_W(16)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a.slave)
    );

    lfsr_checker #(.CNT_W(4)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] nxt(input logic [15:0] d);
        return {d[14:0], ^(d & 16'hB400)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock edge: inputs set after the falling edge, outputs sampled 1 ns after the rising edge.
    task automatic step(input bit sel_b, input bit rst, input bit vld,
                        input logic [15:0] data, input bit clr);
        @(negedge clk);
        reset            = rst;
        bus_a.in_valid   = 1'b0;
        bus_a.in_data    = 16'h0;
        bus_a.clr_counts = 1'b0;
        bus_b.in_valid   = 1'b0;
        bus_b.in_data    = 16'h0;
        bus_b.clr_counts = 1'b0;
        if (sel_b) begin
            bus_b.in_valid   = vld;
            bus_b.in_data    = data;
            bus_b.clr_counts = clr;
        end else begin
            bus_a.in_valid   = vld;
            bus_a.in_data    = data;
            bus_a.clr_counts = clr;
        end
        @(posedge clk);
        #1;
        $display("t=%0t bus=%s rst=%0d vld=%0d data=0x%04h clr=%0d | A lk=%0d ep=%0d mc=%0d ec=%0d | B lk=%0d mc=%0d",
                 $time, sel_b ? "B" : "A", rst, vld, data, clr,
                 bus_a.locked, bus_a.err_pulse, bus_a.match_count, bus_a.err_count,
                 bus_b.locked, bus_b.match_count);
    endtask

    initial begin
        logic [15:0] w;
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        bus_a.in_valid = 1'b0; bus_a.in_data = 16'h0; bus_a.clr_counts = 1'b0;
        bus_b.in_valid = 1'b0; bus_b.in_data = 16'h0; bus_b.clr_counts = 1'b0;

        step(0, 1, 0, 16'h0, 0);
        step(0, 1, 0, 16'h0, 0);
        chk("rst_locked", bus_a.locked, 0);
        chk("rst_err_pulse", bus_a.err_pulse, 0);
        chk("rst_match", bus_a.match_count, 0);
        chk("rst_err", bus_a.err_count, 0);
        chk("rst_b_match", bus_b.match_count, 0);

        // Lock acquisition.
        step(0, 0, 1, 16'd2, 0);  chk("acq_2", bus_a.locked, 0);
        step(0, 0, 1, 16'd4, 0);  chk("acq_4", bus_a.locked, 0);
        step(0, 0, 1, 16'd8, 0);  chk("acq_8", bus_a.locked, 0);
        step(0, 0, 1, 16'd16, 0); chk("acq_16", bus_a.locked, 1);
        chk("acq_match", bus_a.match_count, 0);
        chk("acq_err", bus_a.err_count, 0);

        // Tracking with one corrupted word.
        step(0, 0, 1, 16'd32, 0);    chk("trk_mc1", bus_a.match_count, 1);
        chk("trk_ep0", bus_a.err_pulse, 0);
        step(0, 0, 1, 16'hFFFF, 0);  chk("trk_ep1", bus_a.err_pulse, 1);
        chk("trk_ec1", bus_a.err_count, 1);
        chk("trk_lk", bus_a.locked, 1);
        step(0, 0, 1, 16'd128, 0);   chk("trk_ep_clear", bus_a.err_pulse, 0);
        chk("trk_mc2", bus_a.match_count, 2);
        step(0, 0, 1, 16'd256, 0);   chk("trk_mc3", bus_a.match_count, 3);
        chk("trk_ec_final", bus_a.err_count, 1);
        chk("trk_lk_final", bus_a.locked, 1);

        // Idle edge with clear: counters zeroed, lock kept.
        step(0, 0, 0, 16'h0, 1);
        chk("clr_mc", bus_a.match_count, 0);
        chk("clr_ec", bus_a.err_count, 0);
        chk("clr_lk", bus_a.locked, 1);

        // Loss of lock after three consecutive mismatches, then relock.
        step(0, 0, 1, 16'h0001, 0); chk("loss1_ep", bus_a.err_pulse, 1); chk("loss1_lk", bus_a.locked, 1);
        step(0, 0, 1, 16'h0001, 0); chk("loss2_ep", bus_a.err_pulse, 1); chk("loss2_lk", bus_a.locked, 1);
        step(0, 0, 1, 16'h0001, 0); chk("loss3_ep", bus_a.err_pulse, 1); chk("loss3_lk", bus_a.locked, 0);
        chk("loss_ec", bus_a.err_count, 3);
        step(0, 0, 1, 16'd2, 0);  chk("relk_2", bus_a.locked, 0);
        chk("relk_ep0", bus_a.err_pulse, 0);
        step(0, 0, 1, 16'd4, 0);  chk("relk_4", bus_a.locked, 0);
        step(0, 0, 1, 16'd8, 0);  chk("relk_8", bus_a.locked, 0);
        step(0, 0, 1, 16'd16, 0); chk("relk_16", bus_a.locked, 1);
        chk("relk_ec", bus_a.err_count, 3);
        chk("relk_mc", bus_a.match_count, 0);

        // Hunt robustness from a fresh reset, with idle gaps.
        step(0, 1, 0, 16'h0, 0);  chk("hunt_rst_lk", bus_a.locked, 0);
        step(0, 0, 1, 16'd0, 0);  chk("hunt_z1", bus_a.locked, 0);
        step(0, 0, 1, 16'd0, 0);  chk("hunt_z2", bus_a.locked, 0);
        step(0, 0, 1, 16'd5, 0);  chk("hunt_5", bus_a.locked, 0);
        step(0, 0, 0, 16'd10, 0); chk("hunt_gap1", bus_a.locked, 0);
        step(0, 0, 1, 16'd7, 0);  chk("hunt_7", bus_a.locked, 0);
        step(0, 0, 1, 16'd14, 0); chk("hunt_14", bus_a.locked, 0);
        step(0, 0, 0, 16'd28, 0); chk("hunt_gap2", bus_a.locked, 0);
        step(0, 0, 1, 16'd28, 0); chk("hunt_28", bus_a.locked, 0);
        step(0, 0, 1, 16'd56, 0); chk("hunt_56", bus_a.locked, 1);
        chk("hunt_mc", bus_a.match_count, 0);

        // Clear coincident with a mismatch, then reset while locked. Predictor now at 112.
        step(0, 0, 1, 16'h0001, 0); chk("cr_ec1", bus_a.err_count, 1);
        step(0, 0, 1, 16'd224, 0);  chk("cr_mc1", bus_a.match_count, 1);
        step(0, 0, 1, 16'h0001, 0); chk("cr_ec2", bus_a.err_count, 2);
        chk("cr_lk", bus_a.locked, 1);
        step(0, 0, 1, 16'h0001, 1);
        chk("cr_clr_ec", bus_a.err_count, 0);
        chk("cr_clr_mc", bus_a.match_count, 0);
        chk("cr_clr_ep", bus_a.err_pulse, 1);
        chk("cr_clr_lk", bus_a.locked, 1);
        step(0, 1, 1, 16'd1792, 0);
        chk("cr_rst_lk", bus_a.locked, 0);
        chk("cr_rst_ep", bus_a.err_pulse, 0);
        chk("cr_rst_mc", bus_a.match_count, 0);
        chk("cr_rst_ec", bus_a.err_count, 0);

        // Saturation on the 4-bit counter instance.
        step(1, 0, 1, 16'd2, 0);
        step(1, 0, 1, 16'd4, 0);
        step(1, 0, 1, 16'd8, 0);
        step(1, 0, 1, 16'd16, 0);
        chk("sat_lk", bus_b.locked, 1);
        w = 16'd32;
        for (int i = 0; i < 20; i++) begin
            step(1, 0, 1, w, 0);
            w = nxt(w);
            if (i == 13) chk("sat_mc14", bus_b.match_count, 14);
            if (i == 14) chk("sat_mc15", bus_b.match_count, 15);
        end
        chk("sat_hold", bus_b.match_count, 15);
        chk("sat_ec", bus_b.err_count, 0);
        chk("sat_lk_end", bus_b.locked, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
